// File: rtl/mult_share_arb_if.sv
// Bundle of requester-side and multiplier-side signals for the shared-multiplier arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters plus multiplier).
interface mult_share_arb_if;
  logic        req0;
  logic        req1;
  logic [7:0]  a0;
  logic [7:0]  b0;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        ack0;
  logic        ack1;
  logic [15:0] result;
  logic        err;
  logic        busy;
  logic        grant_id;
  logic [1:0]  state_out;
  logic        mult_start;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic        mult_done;
  logic [15:0] mult_product;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mult_done, mult_product,
    output ack0, ack1, result, err, busy, grant_id, state_out,
           mult_start, mult_a, mult_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mult_done, mult_product,
    input  ack0, ack1, result, err, busy, grant_id, state_out,
           mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one sequential 8x8 multiplier between two requesters,
// with a watchdog that aborts a multiplication that never reports done.
module mult_share_arb #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            reset_a,
  mult_share_arb_if.slave bus
);
  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic               grant_q, grant_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [OP_W-1:0]    a_q, a_d;
  logic [OP_W-1:0]    b_q, b_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               win;
  logic               fin;

  // Next-state and registered-output computation; result/err/ack only live in RESP.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    start_d  = 1'b0;
    err_d    = 1'b0;
    result_d = '0;
    fin      = 1'b0;
    win      = bus.req1 & (~bus.req0 | prio_q);

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          grant_d = win;
          a_d     = win ? bus.a1 : bus.a0;
          b_d     = win ? bus.b1 : bus.b0;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // done takes precedence over an expiring watchdog in the same cycle
        if (bus.mult_done) begin
          result_d = bus.mult_product;
          fin      = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          fin   = 1'b1;
        end
        if (fin) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = RESP;
        end
      end
      RESP: begin
        prio_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.result     = result_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.state_out  = state_q;
  assign bus.mult_start = start_q;
  assign bus.mult_a     = a_q;
  assign bus.mult_b     = b_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: behavioural multiplier with programmable latency,
// a table of single operations and hand-written multi-cycle sequences.
module tb_mult_share_arb;
  logic clk;
  logic reset_a;
  mult_share_arb_if bus ();

  mult_share_arb #(.TIMEOUT(31)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int lat      = 4;
  bit mult_dead = 1'b0;
  int pend     = 0;
  int start_cnt = 0;
  int ack0_cnt  = 0;
  int ack1_cnt  = 0;

  // Multiplier stand-in: done pulses 'lat' cycles after the start cycle.
  always @(negedge clk or posedge reset_a) begin
    if (reset_a) begin
      pend = 0;
      bus.mult_done = 1'b0;
      bus.mult_product = 16'h0;
    end else begin
      bus.mult_done = 1'b0;
      if (bus.mult_start) begin
        pend = mult_dead ? 0 : lat;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mult_done = 1'b1;
          bus.mult_product = 16'(bus.mult_a) * 16'(bus.mult_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mult_start) start_cnt++;
    if (bus.ack0) ack0_cnt++;
    if (bus.ack1) ack1_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input string nm, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.ack0 || bus.ack1) && n < 300);
    chk({nm, "_ack_seen"}, {31'd0, bus.ack0 | bus.ack1}, 32'd1);
  endtask

  task automatic wait_wait_state(input string nm);
    int n = 0;
    while (bus.state_out != 2'd2 && n < 300) begin
      tick();
      n++;
    end
    chk({nm, "_reach_wait"}, {30'd0, bus.state_out}, 32'd2);
  endtask

  typedef struct {
    bit          sel;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] res;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    int c0, c1, s0;
    logic [15:0] exp_ab;

    tbl[0] = '{1'b0, 8'h0F, 8'h0F, 18, 16'h00E1};
    tbl[1] = '{1'b1, 8'h02, 8'h03,  5, 16'h0006};
    tbl[2] = '{1'b0, 8'hFF, 8'hFF,  3, 16'hFE01};
    tbl[3] = '{1'b1, 8'h12, 8'h34,  1, 16'h03A8};
    tbl[4] = '{1'b0, 8'h00, 8'hAB,  7, 16'h0000};
    tbl[5] = '{1'b1, 8'h80, 8'h02, 10, 16'h0100};
    tbl[6] = '{1'b0, 8'hFF, 8'h01, 19, 16'h00FF};
    tbl[7] = '{1'b1, 8'h0B, 8'h0D, 31, 16'h008F};

    reset_a = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = 8'h0; bus.b0 = 8'h0; bus.a1 = 8'h0; bus.b1 = 8'h0;
    tick(); tick();

    chk("rst_state", {30'd0, bus.state_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_start", {31'd0, bus.mult_start}, 32'd0);
    chk("rst_ack_err", {29'd0, bus.ack0, bus.ack1, bus.err}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_operands", {16'd0, bus.mult_a, bus.mult_b}, 32'd0);
    chk("rst_grant", {31'd0, bus.grant_id}, 32'd0);
    reset_a = 1'b0;
    tick();

    // Simultaneous requests right after reset: requester 0 wins first.
    lat = 4;
    s0 = start_cnt;
    bus.a0 = 8'hFF; bus.b0 = 8'hFF; bus.a1 = 8'h12; bus.b1 = 8'h34;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_ack("sim0", n);
    chk("sim_first_ack", {30'd0, bus.ack0, bus.ack1}, 32'b10);
    chk("sim_first_res", {16'd0, bus.result}, 32'h0000FE01);
    bus.req0 = 1'b0;
    wait_ack("sim1", n);
    chk("sim_second_ack", {30'd0, bus.ack0, bus.ack1}, 32'b01);
    chk("sim_second_res", {16'd0, bus.result}, 32'h000003A8);
    chk("sim_second_err", {31'd0, bus.err}, 32'd0);
    bus.req1 = 1'b0;
    tick();
    chk("sim_start_pulses", start_cnt - s0, 32'd2);

    // Fairness: both held high, grants alternate starting from 0.
    bus.a0 = 8'h03; bus.b0 = 8'h05; bus.a1 = 8'h07; bus.b1 = 8'h09;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_wait_state("fair");
      chk("fair_grant", {31'd0, bus.grant_id}, 32'(k % 2));
      exp_ab = (k % 2 == 1) ? 16'h0709 : 16'h0305;
      chk("fair_operands", {16'd0, bus.mult_a, bus.mult_b}, {16'd0, exp_ab});
      wait_ack("fair", n);
      chk("fair_ack", {30'd0, bus.ack0, bus.ack1}, (k % 2 == 1) ? 32'b01 : 32'b10);
      chk("fair_res", {16'd0, bus.result}, (k % 2 == 1) ? 32'h3F : 32'h0F);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // Table of single operations, including done coinciding with the watchdog.
    foreach (tbl[i]) begin
      lat = tbl[i].lat;
      c0 = ack0_cnt; c1 = ack1_cnt;
      if (tbl[i].sel) begin
        bus.a1 = tbl[i].a; bus.b1 = tbl[i].b; bus.req1 = 1'b1;
      end else begin
        bus.a0 = tbl[i].a; bus.b0 = tbl[i].b; bus.req0 = 1'b1;
      end
      wait_ack("vec", n);
      chk($sformatf("vec%0d_latency", i), n + 1, tbl[i].lat + 3);
      chk($sformatf("vec%0d_ack", i), {30'd0, bus.ack0, bus.ack1},
          tbl[i].sel ? 32'b01 : 32'b10);
      chk($sformatf("vec%0d_res", i), {16'd0, bus.result}, {16'd0, tbl[i].res});
      chk($sformatf("vec%0d_err", i), {31'd0, bus.err}, 32'd0);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick();
      chk($sformatf("vec%0d_idle_after", i),
          {27'd0, bus.state_out, bus.ack0, bus.ack1, bus.result != 16'h0}, 32'd0);
      chk($sformatf("vec%0d_other_ack", i),
          tbl[i].sel ? ack0_cnt - c0 : ack1_cnt - c1, 32'd0);
    end

    // Watchdog: dead multiplier, ack lands in cycle TIMEOUT+2 counting the start cycle as 1.
    mult_dead = 1'b1;
    bus.a0 = 8'h05; bus.b0 = 8'h06; bus.req0 = 1'b1;
    tick();
    chk("to_start", {31'd0, bus.mult_start}, 32'd1);
    n = 1;
    do begin
      tick();
      n++;
    end while (!(bus.ack0 || bus.ack1) && n < 300);
    chk("to_cycles", n, 32'd33);
    chk("to_ack", {30'd0, bus.ack0, bus.ack1}, 32'b10);
    chk("to_err", {31'd0, bus.err}, 32'd1);
    chk("to_result", {16'd0, bus.result}, 32'd0);
    bus.req0 = 1'b0;
    tick();
    chk("to_err_cleared", {31'd0, bus.err}, 32'd0);
    mult_dead = 1'b0;
    lat = 6;
    bus.req0 = 1'b1;
    wait_ack("after_to", n);
    chk("after_to_res", {16'd0, bus.result}, 32'h1E);
    chk("after_to_err", {31'd0, bus.err}, 32'd0);
    bus.req0 = 1'b0;
    tick();

    // Reset five cycles into WAIT: everything drops at once and no ack follows.
    lat = 20;
    bus.a0 = 8'h07; bus.b0 = 8'h07; bus.req0 = 1'b1;
    tick();
    tick();
    chk("rw_in_wait", {30'd0, bus.state_out}, 32'd2);
    for (int k = 0; k < 5; k++) tick();
    c0 = ack0_cnt;
    reset_a = 1'b1;
    #1;
    chk("rw_busy", {31'd0, bus.busy}, 32'd0);
    chk("rw_state", {30'd0, bus.state_out}, 32'd0);
    chk("rw_start_ack", {29'd0, bus.mult_start, bus.ack0, bus.ack1}, 32'd0);
    tick(); tick();
    bus.req0 = 1'b0;
    reset_a = 1'b0;
    for (int k = 0; k < 25; k++) tick();
    chk("rw_no_ack", ack0_cnt - c0, 32'd0);
    lat = 4;
    bus.a1 = 8'h02; bus.b1 = 8'h03; bus.req1 = 1'b1;
    wait_ack("rw_after", n);
    chk("rw_after_ack", {30'd0, bus.ack0, bus.ack1}, 32'b01);
    chk("rw_after_res", {16'd0, bus.result}, 32'h6);
    bus.req1 = 1'b0;
    tick();

    // Requester 0 drops mid-operation; its ack still pulses once, then req1 is served.
    lat = 8;
    c0 = ack0_cnt;
    bus.a0 = 8'h04; bus.b0 = 8'h04; bus.req0 = 1'b1;
    tick(); tick();
    bus.req0 = 1'b0;
    bus.a1 = 8'h09; bus.b1 = 8'h09; bus.req1 = 1'b1;
    wait_ack("drop0", n);
    chk("drop_ack0", {30'd0, bus.ack0, bus.ack1}, 32'b10);
    chk("drop_res0", {16'd0, bus.result}, 32'h10);
    wait_ack("drop1", n);
    chk("drop_ack1", {30'd0, bus.ack0, bus.ack1}, 32'b01);
    chk("drop_res1", {16'd0, bus.result}, 32'h51);
    chk("drop_ack0_once", ack0_cnt - c0, 32'd1);
    bus.req1 = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one 8x8 sequential multiplier (the 4x4-multiplier/shift/accumulate datapath plus its control FSM) between two requesters. It latches the winning requester's operands, drives the multiplier's start handshake, waits for `done`, and returns the 16-bit product with a one-cycle acknowledge. A watchdog recovers from a multiplier that never completes, for example one whose control FSM has entered its error state.

## Interface
- `TIMEOUT`, default 31. Maximum WAIT cycles before abort. Legal range 20..255; the multiplier normally completes well inside 20 cycles.
- `clk` input, 1 bit: the single clock; all registers on its rising edge.
- `reset_a` input, 1 bit: asynchronous reset, active-high.
- `req0`, `req1` input, 1 bit each: requests. Held high until the matching ack.
- `a0`, `b0`, `a1`, `b1` input, 8 bits each: unsigned operands. Held stable while the matching req is high.
- `ack0`, `ack1` output, 1 bit each: one-cycle completion pulse to the served requester.
- `result` output, 16 bits: product, valid only in an ack cycle.
- `err` output, 1 bit: high with ack when the operation timed out.
- `busy` output, 1 bit: high in every state other than IDLE.
- `grant_id` output, 1 bit: requester currently being served.
- `state_out` output, 2 bits: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
- `mult_start` output, 1 bit: start pulse to the multiplier control.
- `mult_a`, `mult_b` output, 8 bits each: operands to the multiplier.
- `mult_done` input, 1 bit: multiplier done indication.
- `mult_product` input, 16 bits: multiplier result.

## Operation
- Reset values: all outputs 0; state IDLE; priority pointer `prio` = 0; timeout counter 0; operand registers 0.
- IDLE, no req: remain in IDLE.
- IDLE, one req high: grant that requester.
- IDLE, both reqs high: grant requester `prio`.
- On any grant:
  - Latch the winner's a/b into the operand registers.
  - Set `grant_id` to the winner.
  - Move to ISSUE.
- ISSUE:
  - `mult_start`=1 for exactly this one cycle.
  - `mult_a`/`mult_b` driven from the operand registers.
  - Next state WAIT; timeout counter cleared.
- WAIT:
  - `mult_start`=0; operands stay stable on `mult_a`/`mult_b`.
  - Counter increments every cycle.
  - If `mult_done`=1: capture `mult_product` into the result register, clear the error flag, go to RESP.
  - Otherwise, when counter = TIMEOUT-1: result register = 0, error flag = 1, go to RESP.
  - `mult_done` wins if it coincides with timeout.
- RESP:
  - The ack for `grant_id` = 1; `result` and `err` driven from their registers.
  - `prio` = ~`grant_id`.
  - Next state IDLE.
- `result` and `err` are 0 outside RESP.
- Requests are sampled only in IDLE. A req dropped mid-operation does not abort; the ack still pulses and the requester ignores it.
- After a timeout, the next ISSUE start pulse restarts the multiplier. Its control FSM leaves its error state on `start`. No extra recovery logic.
- Arithmetic: the product is unsigned 8x8→16, taken verbatim from the multiplier. No truncation or rounding.
- The counter width holds TIMEOUT-1 (8 bits suffices).

## Timing
- Request seen in IDLE at edge T: ISSUE during T..T+1, `mult_start` high for that one cycle; WAIT from T+1.
- `mult_done` high in WAIT at cycle D: RESP (ack high) in cycle D+1; IDLE at D+2.
- Request-to-ack latency = multiplier latency + 3 cycles.
- Minimum spacing between two grants: the RESP cycle plus one IDLE cycle.
- Back-to-back, both reqs held high: grants alternate 0,1,0,1…
- Timeout: with `mult_done` never high, ack with `err`=1 arrives TIMEOUT+2 cycles after ISSUE.
- `reset_a` mid-operation: immediate return to IDLE with all outputs 0, including `mult_start`. No ack is produced for the aborted request.

## Test plan
- Single op: `req0` with a0=0x0F, b0=0x0F; multiplier model returns after 18 cycles → one `ack0` pulse, `result`=0x00E1, `err`=0, `ack1` never high.
- Simultaneous: `req0` (0xFF×0xFF) and `req1` (0x12×0x34) rise together after reset → `ack0` first with `result`=0xFE01, then `ack1` with `result`=0x03A8. `mult_start` pulses exactly twice.
- Fairness: both reqs held high for 4 operations → ack order 0,1,0,1; `grant_id` toggles; operands on `mult_a`/`mult_b` match the granted requester during each WAIT.
- Timeout: `mult_done` tied 0, TIMEOUT=31 → ack with `err`=1 and `result`=0x0000 exactly 33 cycles after `mult_start`. A following request with a working multiplier completes normally with `err`=0.
- Reset mid-WAIT: assert `reset_a` 5 cycles into WAIT → same cycle `busy`=0, `state_out`=0, `mult_start`=0, no ack. After release, `req1` (0x02×0x03) yields `result`=0x0006.
- Request dropped: `req0` deasserted in WAIT → `ack0` still pulses once; the arbiter returns to IDLE and accepts `req1` next.
